multi_cycle_control: RTL

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/mips_ctrl_pkg.sv | 61 ++++++
 rtl/alu_decoder.sv | 28 ++
 rtl/multi_cycle_control.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// instruction field constants, ALU codes and datapath mux encodings.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1110;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for every opcode the control unit knows how to sequence.
    function automatic logic is_known_opcode(input logic [5:0] op);
        logic known;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ORI: known = 1'b1;
            default: known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type funct field to its ALU operation and flags unsupported functs.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       funct_valid
);

    // Pure lookup; unknown functs fall back to ADD with the valid flag low.
    always_comb begin
        alu_control = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            FN_SLL:  alu_control = ALU_SLL;
            default: begin
                alu_control = ALU_ADD;
                funct_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM of a multi-cycle MIPS datapath; control outputs are
// decoded combinationally from the current state and instruction fields.
module multi_cycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [3:0] alu_control,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] funct_alu_s;
    logic       funct_valid_s;
    logic       decode_bad_s;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .alu_control (funct_alu_s),
        .funct_valid (funct_valid_s)
    );

    assign state = state_r;

    // An instruction is rejected in DECODE for an unknown opcode or an unsupported R-type funct.
    always_comb begin
        if (opcode == OP_RTYPE) begin
            decode_bad_s = ~funct_valid_s;
        end else begin
            decode_bad_s = ~is_known_opcode(opcode);
        end
    end

    // Output decode and next-state selection for the current state.
    always_comb begin
        next_state_s  = S_FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        pc_source     = PCSRC_ALU;
        alu_control   = ALU_ADD;
        illegal       = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                if (decode_bad_s) begin
                    illegal      = 1'b1;
                    next_state_s = S_FETCH;
                end else begin
                    case (opcode)
                        OP_RTYPE:       next_state_s = S_R_EXEC;
                        OP_LW, OP_SW:   next_state_s = S_MEM_ADDR;
                        OP_BEQ, OP_BNE: next_state_s = S_BRANCH;
                        OP_J:           next_state_s = S_JUMP;
                        OP_ADDI, OP_ORI: next_state_s = S_I_EXEC;
                        default:        next_state_s = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode == OP_SW) begin
                    next_state_s = S_MEM_WR;
                end else begin
                    next_state_s = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    next_state_s = S_MEM_WB;
                end else begin
                    next_state_s = S_MEM_RD;
                end
            end
            S_MEM_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEM_WR;
                end
            end
            S_R_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_REGB;
                alu_control  = funct_alu_s;
                next_state_s = S_ALU_WB;
            end
            S_I_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                if (opcode == OP_ORI) begin
                    alu_control = ALU_OR;
                end else begin
                    alu_control = ALU_ADD;
                end
                next_state_s = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write    = 1'b1;
                reg_dst      = (opcode == OP_RTYPE);
                next_state_s = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REGB;
                alu_control   = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                branch_ne     = (opcode == OP_BNE);
                next_state_s  = S_FETCH;
            end
            S_JUMP: begin
                pc_write     = 1'b1;
                pc_source    = PCSRC_JUMP;
                next_state_s = S_FETCH;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

    // State register; the synchronous reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

endmodule
